// File: rtl/pixel_packer.sv
// Packs a serial pixel stream into PIXCNT-lane words and enforces frame geometry,
// padding short lines and dropping overrun pixels. Error flags need PIXEL_PACKER_ERR_EN.
module pixel_packer #(
  parameter int DWIDTH = 10,
  parameter int PIXCNT = 8,
  parameter int ROWS   = 2048,
  parameter int COLS   = 2448
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [$clog2(ROWS)-1:0]    rowSize,
  input  logic [$clog2(COLS)-1:0]    colSize,
  input  logic [DWIDTH-1:0]          pix_in,
  input  logic                       pix_vld,
  input  logic                       pix_sof,
  input  logic                       pix_eol,
  output logic                       new_frame,
  output logic [DWIDTH*PIXCNT-1:0]   data_out,
  output logic                       data_vld,
  output logic                       frame_done,
  output logic [3:0]                 err_flags
);

  localparam int LW = $clog2(PIXCNT);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int WW = DWIDTH * PIXCNT;
  localparam logic [LW-1:0] LANE_LAST = LW'(PIXCNT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LINE    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  // Handshake: pix_vld has no ready, so every valid pixel is consumed in the cycle
  // it is presented; data_vld is a one-cycle strobe with no ready either.

  state_t          r_state;
  logic [LW-1:0]   r_lane;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   r_rows_cfg;
  logic [CW-1:0]   r_cols_cfg;
  logic [WW-1:0]   r_word;
  logic [WW-1:0]   r_data_out;
  logic            r_data_vld;
  logic            r_new_frame;
  logic            r_frame_done;

  logic            w_start;
  logic            w_accept;
  logic [LW-1:0]   w_lane;
  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic [RW-1:0]   w_rows_cfg;
  logic [CW-1:0]   w_cols_cfg;
  logic [CW-1:0]   w_col_inc;
  logic [RW-1:0]   w_row_inc;
  logic            w_last_col;
  logic            w_line_end;
  logic            w_frame_end;
  logic            w_emit;
  logic [WW-1:0]   w_word;

  state_t          w_state_nxt;
  logic [LW-1:0]   w_lane_nxt;
  logic [CW-1:0]   w_col_nxt;
  logic [RW-1:0]   w_row_nxt;

  // An SOF pixel restarts everything in any state, so counters are taken as zero for it.
  assign w_start     = pix_vld & pix_sof;
  assign w_accept    = w_start | (pix_vld & (r_state == S_LINE));
  assign w_lane      = w_start ? '0 : r_lane;
  assign w_col       = w_start ? '0 : r_col;
  assign w_row       = w_start ? '0 : r_row;
  assign w_rows_cfg  = w_start ? rowSize : r_rows_cfg;
  assign w_cols_cfg  = w_start ? colSize : r_cols_cfg;
  assign w_col_inc   = w_col + CW'(1);
  assign w_row_inc   = w_row + RW'(1);
  assign w_last_col  = (w_col_inc == w_cols_cfg);
  assign w_line_end  = w_accept & (pix_eol | w_last_col);
  assign w_frame_end = w_line_end & (w_row_inc == w_rows_cfg);
  assign w_emit      = w_accept & ((w_lane == LANE_LAST) | w_line_end);

  // Lanes below the current one come from the buffer; the current lane and every
  // lane above it take the incoming pixel, which is the end-of-line padding.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < PIXCNT; k++) begin
      if (k < int'(w_lane)) w_word[k*DWIDTH +: DWIDTH] = r_word[k*DWIDTH +: DWIDTH];
      else                  w_word[k*DWIDTH +: DWIDTH] = pix_in;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    if (w_accept) begin
      if (w_line_end) begin
        w_lane_nxt = '0;
        w_col_nxt  = '0;
        if (w_frame_end) begin
          w_row_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_row_nxt   = w_row_inc;
          w_state_nxt = pix_eol ? S_LINE : S_DISCARD;
        end
      end else begin
        w_lane_nxt  = w_lane + LW'(1);
        w_col_nxt   = w_col_inc;
        w_row_nxt   = w_row;
        w_state_nxt = S_LINE;
      end
    end else if (pix_vld && pix_eol && (r_state == S_DISCARD)) begin
      w_lane_nxt  = '0;
      w_col_nxt   = '0;
      w_state_nxt = S_LINE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_rows_cfg <= '0;
      r_cols_cfg <= '0;
      r_word     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      if (w_start) begin
        r_rows_cfg <= rowSize;
        r_cols_cfg <= colSize;
      end
      if (w_accept) r_word <= w_word;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_data_out   <= '0;
      r_data_vld   <= 1'b0;
      r_new_frame  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_data_vld   <= w_emit;
      r_new_frame  <= w_start;
      r_frame_done <= w_frame_end;
      if (w_emit) r_data_out <= w_word;
    end
  end

  assign data_out   = r_data_out;
  assign data_vld   = r_data_vld;
  assign new_frame  = r_new_frame;
  assign frame_done = r_frame_done;

`ifdef PIXEL_PACKER_ERR_EN
  logic [3:0] r_err;
  logic [3:0] w_err_nxt;

  // SOF clears the flags first, so an early SOF leaves only bit 2 for the new frame.
  always_comb begin
    w_err_nxt = r_err;
    if (w_start) w_err_nxt = (r_state != S_IDLE) ? 4'b0100 : 4'b0000;
    if (w_line_end && pix_eol && !w_last_col) w_err_nxt[0] = 1'b1;
    if (w_line_end && !pix_eol)               w_err_nxt[1] = 1'b1;
    if (pix_vld && !pix_sof && (r_state == S_IDLE)) w_err_nxt[3] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_err <= 4'b0;
    else            r_err <= w_err_nxt;
  end

  assign err_flags = r_err;
`else
  assign err_flags = 4'b0;
`endif

endmodule
